adv7513_cfg_sequencer: RTL and testbench

//  Walks a parametrised {reg,value} config program ROM and turns each entry into an I2C register write to the ADV7513.

---
 rtl/adv7513_cfg_sequencer.sv | 154 +++++++++++++++
 tb/tb_adv7513_cfg_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv7513_cfg_sequencer.sv
// ADV7513 configuration sequencer: replays a {reg,value} ROM program as I2C
// register writes, with END/DELAY opcodes, NACK retry and restartable runs.
module adv7513_cfg_sequencer #(
    parameter int unsigned ROM_AW    = 8,
    parameter logic [6:0]  DEV_ADDR  = 7'h39,
    parameter logic [15:0] END_WORD  = 16'hFFFF,
    parameter logic [7:0]  DLY_OPC   = 8'hFE,
    parameter int unsigned DLY_UNIT  = 1000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              i2c_valid,
    input  logic              i2c_ready,
    output logic [6:0]        i2c_dev,
    output logic [7:0]        i2c_reg,
    output logic [7:0]        i2c_wdata,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_index,
    output logic [ROM_AW:0]   wr_count
);

    localparam int unsigned DLY_W = $clog2(255 * DLY_UNIT + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0]  RETRY_LIMIT = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0]  RETRY_ONE   = RTY_W'(1);
    localparam logic [ROM_AW-1:0] LAST_ADDR   = '1;
    localparam logic [ROM_AW-1:0] ADDR_ONE    = ROM_AW'(1);
    localparam logic [ROM_AW:0]   COUNT_ONE   = (ROM_AW + 1)'(1);
    localparam logic [DLY_W-1:0]  DLY_ONE     = DLY_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_WAIT, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t            state_reg, state_next, adv_state;
    logic [ROM_AW-1:0] rom_addr_reg, err_index_reg;
    logic [ROM_AW:0]   wr_count_reg;
    logic [7:0]        reg_idx_reg, wdata_reg;
    logic [RTY_W-1:0]  retry_reg;
    logic [DLY_W-1:0]  dly_cnt_reg;
    logic              is_end, is_dly, dly_zero, at_last, retry_left;

    assign is_end     = (rom_data == END_WORD);
    assign is_dly     = (rom_data[15:8] == DLY_OPC);
    assign dly_zero   = (rom_data[7:0] == 8'd0);
    assign at_last    = (rom_addr_reg == LAST_ADDR);
    assign retry_left = (retry_reg < RETRY_LIMIT);
    // Stepping past the last ROM slot without seeing END is an overrun.
    assign adv_state  = at_last ? S_ERROR : S_FETCH;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (is_end)        state_next = S_DONE;
                else if (!is_dly)  state_next = S_WRITE;
                else if (dly_zero) state_next = adv_state;
                else               state_next = S_DELAY;
            end
            S_WRITE:  if (i2c_ready) state_next = S_WAIT;
            S_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack)      state_next = adv_state;
                    else if (retry_left) state_next = S_WRITE;
                    else                state_next = S_ERROR;
                end
            end
            S_DELAY:  if (dly_cnt_reg == DLY_ONE) state_next = adv_state;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        i2c_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_reg)
            S_FETCH, S_DECODE, S_WAIT, S_DELAY: busy = 1'b1;
            S_WRITE: begin
                busy      = 1'b1;
                i2c_valid = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_reg  <= '0;
            err_index_reg <= '0;
            wr_count_reg  <= '0;
            reg_idx_reg   <= '0;
            wdata_reg     <= '0;
            retry_reg     <= '0;
            dly_cnt_reg   <= '0;
        end else begin
            if (state_next == S_FETCH) begin
                if (state_reg inside {S_IDLE, S_DONE, S_ERROR}) begin
                    rom_addr_reg  <= '0;
                    wr_count_reg  <= '0;
                    retry_reg     <= '0;
                    err_index_reg <= '0;
                end else begin
                    rom_addr_reg <= rom_addr_reg + ADDR_ONE;
                end
            end
            if (state_reg == S_DECODE && state_next == S_WRITE) begin
                reg_idx_reg <= rom_data[15:8];
                wdata_reg   <= rom_data[7:0];
            end
            // The delay state lasts exactly N*DLY_UNIT cycles; the counter reaches 0 on exit.
            if (state_reg == S_DECODE && state_next == S_DELAY)
                dly_cnt_reg <= DLY_W'(rom_data[7:0] * DLY_UNIT);
            else if (state_reg == S_DELAY)
                dly_cnt_reg <= dly_cnt_reg - DLY_ONE;
            if (state_reg == S_WAIT && i2c_done) begin
                if (!i2c_nack) begin
                    wr_count_reg <= wr_count_reg + COUNT_ONE;
                    retry_reg    <= '0;
                end else if (retry_left) begin
                    retry_reg <= retry_reg + RETRY_ONE;
                end
            end
            if (state_next == S_ERROR && state_reg != S_ERROR)
                err_index_reg <= rom_addr_reg;
        end
    end

    assign rom_addr  = rom_addr_reg;
    assign i2c_dev   = DEV_ADDR;
    assign i2c_reg   = reg_idx_reg;
    assign i2c_wdata = wdata_reg;
    assign err_index = err_index_reg;
    assign wr_count  = wr_count_reg;

endmodule

// File: tb/tb_adv7513_cfg_sequencer.sv
// Bench for adv7513_cfg_sequencer: ROM + I2C master responder, table vectors,
// hand-written corner sequences and randomized programs against a program-level model.
module tb_adv7513_cfg_sequencer;

    localparam int AW     = 3;
    localparam int DEPTH  = 1 << AW;
    localparam int UNIT   = 4;
    localparam int MAXR   = 2;
    localparam int BUDGET = 2000;

    typedef logic [0:DEPTH-1][15:0] prog_t;
    typedef struct {
        prog_t          prog;
        logic [31:0]    nv;      // bit k = NACK on the k-th accepted transfer
        int             lat;
        bit             e_done;
        bit             e_err;
        logic [AW-1:0]  e_eidx;
        int             e_wrc;
        int             e_n;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          i2c_valid, i2c_ready;
    logic [6:0]    i2c_dev;
    logic [7:0]    i2c_reg, i2c_wdata;
    logic          i2c_done, i2c_nack;
    logic          busy, done, error;
    logic [AW-1:0] err_index;
    logic [AW:0]   wr_count;

    adv7513_cfg_sequencer #(
        .ROM_AW(AW), .DEV_ADDR(7'h39), .END_WORD(16'hFFFF),
        .DLY_OPC(8'hFE), .DLY_UNIT(UNIT), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .i2c_valid(i2c_valid), .i2c_ready(i2c_ready), .i2c_dev(i2c_dev),
        .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .busy(busy), .done(done), .error(error),
        .err_index(err_index), .wr_count(wr_count)
    );

    logic [15:0] rom_mem [DEPTH];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // I2C master responder
    logic [31:0] nack_vec     = '0;
    int          att_idx      = 0;
    int          lat_cfg      = 1;
    int          hold_cnt     = 0;
    int          stall_cycles = 0;
    int          pend_cnt     = 0;
    bit          pend_nack    = 1'b0;
    bit          prev_valid   = 1'b0;
    bit          prev_acc     = 1'b0;
    logic [15:0] prev_payload = '0;
    logic [18:0] acc_q [$];

    initial begin
        i2c_ready = 1'b1;
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
    end

    always begin
        @(posedge clk);
        #1;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (reset) begin
            pend_cnt   = 0;
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_acc) begin
                chk("valid_held", {31'd0, i2c_valid}, 1);
                chk("payload_held", {16'd0, i2c_reg, i2c_wdata}, {16'd0, prev_payload});
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = pend_nack;
                end
            end
            if (i2c_valid && hold_cnt > 0) begin
                i2c_ready = 1'b0;
                hold_cnt--;
                stall_cycles++;
                if (hold_cnt == 5) i2c_done = 1'b1;   // stray completion outside WAIT
            end else begin
                i2c_ready = 1'b1;
            end
            if (i2c_valid && i2c_ready) begin
                acc_q.push_back({rom_addr, i2c_reg, i2c_wdata});
                chk("i2c_dev", {25'd0, i2c_dev}, 32'h39);
                pend_nack = (att_idx < 32) ? nack_vec[att_idx] : 1'b0;
                att_idx++;
                pend_cnt = lat_cfg;
            end
            prev_valid   = i2c_valid;
            prev_acc     = i2c_valid && i2c_ready;
            prev_payload = {i2c_reg, i2c_wdata};
        end
    end

    // Program-level reference: walk the entries, consuming one ACK/NACK decision per attempt.
    logic [18:0]   exp_q [$];
    bit            m_done, m_err;
    logic [AW-1:0] m_eidx;
    int            m_wrc;

    task automatic model(input prog_t prog, input logic [31:0] nv);
        int idx = 0;
        int k = 0;
        int tries;
        bit stop = 1'b0;
        exp_q.delete();
        m_done = 1'b0; m_err = 1'b0; m_eidx = '0; m_wrc = 0;
        while (!stop) begin
            if (prog[idx] == 16'hFFFF) begin
                m_done = 1'b1;
                stop = 1'b1;
            end else begin
                if (prog[idx][15:8] != 8'hFE) begin
                    tries = 0;
                    forever begin
                        exp_q.push_back({idx[AW-1:0], prog[idx]});
                        if (!(k < 32 && nv[k])) begin
                            k++;
                            m_wrc++;
                            break;
                        end
                        k++;
                        if (tries == MAXR) begin
                            m_err = 1'b1;
                            m_eidx = idx[AW-1:0];
                            stop = 1'b1;
                            break;
                        end
                        tries++;
                    end
                end
                if (!stop) begin
                    if (idx == DEPTH - 1) begin
                        m_err = 1'b1;
                        m_eidx = idx[AW-1:0];
                        stop = 1'b1;
                    end else begin
                        idx++;
                    end
                end
            end
        end
    endtask

    task automatic load(input prog_t prog, input logic [31:0] nv, input int lat);
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = prog[i];
        model(prog, nv);
        nack_vec = nv;
        att_idx  = 0;
        lat_cfg  = lat;
        acc_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int cyc = 0;
        while (!(done || error) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " finished"}, {31'd0, done | error}, 1);
    endtask

    task automatic wait_writes(input string name, input int n);
        int cyc = 0;
        while (acc_q.size() < n && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " writes seen"}, acc_q.size(), n);
    endtask

    task automatic check_writes(input string name, input int e_n);
        chk({name, " n_writes"}, acc_q.size(), e_n);
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s write%0d", name, i), {13'd0, acc_q[i]}, {13'd0, exp_q[i]});
    endtask

    task automatic run_prog(input string name, input prog_t prog, input logic [31:0] nv,
                            input int lat, input bit e_done, input bit e_err,
                            input logic [AW-1:0] e_eidx, input int e_wrc, input int e_n);
        load(prog, nv, lat);
        pulse_start();
        wait_end(name);
        chk({name, " done"}, {31'd0, done}, {31'd0, e_done});
        chk({name, " error"}, {31'd0, error}, {31'd0, e_err});
        chk({name, " err_index"}, {29'd0, err_index}, {29'd0, e_eidx});
        chk({name, " wr_count"}, {28'd0, wr_count}, e_wrc);
        chk({name, " busy"}, {31'd0, busy}, 0);
        check_writes(name, e_n);
        repeat (2) @(negedge clk);
    endtask

    vec_t  vecs [7];
    prog_t p;
    logic [31:0] nv;
    int t_addr, t_valid, len;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'hFFFF;

        vecs[0] = '{{16'h4110, {7{16'hFFFF}}}, 32'h0, 3, 1'b1, 1'b0, 3'd0, 1, 1};
        vecs[1] = '{{16'h1234, 16'h5678, {6{16'hFFFF}}}, 32'hE, 2, 1'b0, 1'b1, 3'd1, 1, 4};
        vecs[2] = '{{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707, 16'h0808},
                    32'h0, 1, 1'b0, 1'b1, 3'd7, 8, 8};
        vecs[3] = '{{16'hFE00, 16'h2233, {6{16'hFFFF}}}, 32'h1, 1, 1'b1, 1'b0, 3'd0, 1, 2};
        vecs[4] = '{{8{16'hFFFF}}, 32'h0, 1, 1'b1, 1'b0, 3'd0, 0, 0};
        vecs[5] = '{{8{16'hFE01}}, 32'h0, 1, 1'b0, 1'b1, 3'd7, 0, 0};
        vecs[6] = '{{16'h1111, 16'h2222, 16'h3333, {5{16'hFFFF}}}, 32'h6, 2, 1'b1, 1'b0, 3'd0, 3, 5};

        repeat (3) @(negedge clk);
        chk("reset outputs", {2'd0, rom_addr, i2c_valid, i2c_reg, i2c_wdata, busy, done, error,
                              err_index, wr_count}, 0);
        chk("reset i2c_dev", {25'd0, i2c_dev}, 32'h39);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++)
            run_prog($sformatf("vec%0d", v), vecs[v].prog, vecs[v].nv, vecs[v].lat,
                     vecs[v].e_done, vecs[v].e_err, vecs[v].e_eidx, vecs[v].e_wrc, vecs[v].e_n);

        // Delay of 2 units: DELAY occupies 8 cycles, then FETCH/DECODE/WRITE.
        load({16'hFE02, 16'h9803, {6{16'hFFFF}}}, 32'h0, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_addr = 0;
        t_valid = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (t_addr == 0 && rom_addr == 3'd1) t_addr = i;
            if (t_valid == 0 && i2c_valid) begin
                t_valid = i;
                chk("delay payload", {16'd0, i2c_reg, i2c_wdata}, 32'h9803);
            end
        end
        chk("delay advance cycle", t_addr, 3 + 2 * UNIT);
        chk("delay valid cycle", t_valid, 5 + 2 * UNIT);
        wait_end("delay");
        chk("delay wr_count", {28'd0, wr_count}, 1);

        // Ready held low for 10 cycles, with a stray i2c_done injected meanwhile.
        stall_cycles = 0;
        hold_cnt = 10;
        run_prog("hold", {16'h4110, {7{16'hFFFF}}}, 32'h0, 2, 1'b1, 1'b0, 3'd0, 1, 1);
        chk("hold stall cycles", stall_cycles, 10);

        // Start pulse while busy is ignored.
        load({16'h1111, 16'h2222, {6{16'hFFFF}}}, 32'h0, 4);
        pulse_start();
        wait_writes("busy start", 1);
        pulse_start();
        wait_end("busy start");
        chk("busy start wr_count", {28'd0, wr_count}, 2);
        chk("busy start done", {31'd0, done}, 1);
        check_writes("busy start", 2);

        // Reset while waiting on the second transfer, then a clean rerun.
        load({16'h4110, 16'h2222, {6{16'hFFFF}}}, 32'h0, 20);
        pulse_start();
        wait_writes("rst", 2);
        repeat (3) @(negedge clk);
        chk("rst in wait", {29'd0, busy, i2c_valid, wr_count == 4'd1}, 32'h5);
        reset = 1'b1;
        @(negedge clk);
        chk("rst outputs", {2'd0, rom_addr, i2c_valid, i2c_reg, i2c_wdata, busy, done, error,
                            err_index, wr_count}, 0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("rst stays idle", {25'd0, busy, done, error, wr_count}, 0);
        run_prog("rerun", {16'h4110, 16'h2222, {6{16'hFFFF}}}, 32'h0, 2, 1'b1, 1'b0, 3'd0, 2, 2);

        // Randomized programs checked against the program-level model.
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(0, DEPTH);
            for (int e = 0; e < DEPTH; e++) begin
                if (e == len)                      p[e] = 16'hFFFF;
                else if ($urandom_range(0, 4) == 0) p[e] = {8'hFE, 8'($urandom_range(0, 3))};
                else p[e] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
            end
            for (int b = 0; b < 32; b++) nv[b] = ($urandom_range(0, 2) == 0);
            model(p, nv);
            run_prog($sformatf("rand%0d", r), p, nv, $urandom_range(1, 4),
                     m_done, m_err, m_eidx, m_wrc, exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
